// File: rtl/sys_bus_pkg.sv
// -----------------------------------------------------------------------------
// sys_bus_pkg
// Definitions shared by the system-bus responder and the CPU bus side.
//   - bus_state_e : responder FSM states (IDLE / WAIT / RESP)
//   - default data/address widths and storage depth of the CPU bus
//   - wait-state counter width and helpers
// -----------------------------------------------------------------------------
package sys_bus_pkg;

  // Default bus geometry, matching the CPU register size and address space.
  localparam int unsigned BUS_DATA_W = 8;
  localparam int unsigned BUS_ADDR_W = 8;
  localparam int unsigned BUS_DEPTH  = 128;

  // Wait-state counter covers 0..15 extra cycles.
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_ZERO = 4'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 4'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_state_e;

  // State entered from IDLE when a request is accepted: a zero wait-state
  // configuration skips WAIT entirely.
  function automatic bus_state_e accept_state(input logic [CNT_W-1:0] ws);
    if (ws == CNT_ZERO) begin
      return RESP;
    end else begin
      return WAIT;
    end
  endfunction

endpackage

// File: rtl/sys_bus_mem_array.sv
// -----------------------------------------------------------------------------
// sys_bus_mem_array
// Single-port DEPTH x DATA_W storage: registered write, combinational read.
// Contents are deliberately not reset.
// Ports:
//   CLK   in  : rising-edge clock
//   we    in  : write enable for this cycle
//   idx   in  : word index (shared by read and write)
//   wdata in  : write data
//   rdata out : combinational read of word idx
// -----------------------------------------------------------------------------
module sys_bus_mem_array
  import sys_bus_pkg::*;
#(
  parameter int unsigned DATA_W = BUS_DATA_W,
  parameter int unsigned DEPTH  = BUS_DEPTH,
  parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Registered write port; no reset so contents survive RST.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_r[idx] <= wdata;
    end
  end

  assign rdata = mem_r[idx];

endmodule

// File: rtl/sys_bus_responder.sv
// -----------------------------------------------------------------------------
// sys_bus_responder
// Bus responder with programmable wait states in front of a local storage
// array. A request is latched in IDLE, held for WAIT_STATES cycles, and
// completed on the RESP edge, which registers a one-cycle ack_o together with
// err_o/rdata_o. Addresses outside [BASE_ADDR, BASE_ADDR+DEPTH) complete with
// err_o=1 and never touch storage.
// Ports:
//   CLK     in  : rising-edge clock
//   RST     in  : asynchronous active-high reset (storage is kept)
//   req_i   in  : request, held until ack_o
//   we_i    in  : 1 = write, 0 = read
//   addr_i  in  : request address
//   wdata_i in  : write data
//   ack_o   out : one-cycle completion pulse
//   err_o   out : out-of-range flag, only with ack_o
//   rdata_o out : read data, only with ack_o
//   busy_o  out : FSM not in IDLE
// -----------------------------------------------------------------------------
module sys_bus_responder
  import sys_bus_pkg::*;
#(
  parameter int unsigned DATA_W      = BUS_DATA_W,
  parameter int unsigned ADDR_W      = BUS_ADDR_W,
  parameter int unsigned DEPTH       = BUS_DEPTH,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ack_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Decode bounds in ADDR_W+1 bits so BASE_ADDR+DEPTH cannot wrap.
  localparam logic [ADDR_W:0] BASE_EXT  = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] LIMIT_EXT = (ADDR_W+1)'(BASE_ADDR + DEPTH);
  localparam logic [CNT_W-1:0] WS_CNT   = CNT_W'(WAIT_STATES);

  bus_state_e        state_r;
  bus_state_e        state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              ack_r;
  logic              err_r;
  logic [DATA_W-1:0] rdata_r;

  logic [ADDR_W:0]   addr_ext_s;
  logic              in_range_s;
  logic [IDX_W-1:0]  mem_idx_s;
  logic              mem_we_s;
  logic [DATA_W-1:0] mem_rdata_s;

  // Address decode always works on the latched request, never on addr_i.
  assign addr_ext_s  = {1'b0, addr_r};
  assign in_range_s  = (addr_ext_s >= BASE_EXT) && (addr_ext_s < LIMIT_EXT);
  assign mem_idx_s   = IDX_W'(addr_ext_s - BASE_EXT);
  assign mem_we_s    = (state_r == RESP) && we_r && in_range_s;

  sys_bus_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .CLK   (CLK),
    .we    (mem_we_s),
    .idx   (mem_idx_s),
    .wdata (wdata_r),
    .rdata (mem_rdata_s)
  );

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_i) begin
          state_nxt_s = accept_state(WS_CNT);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        // Leave on the 1 -> 0 step; a zero count here is only defensive.
        if (cnt_r <= CNT_ONE) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Request latch, wait counter and registered response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r   <= CNT_ZERO;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      // Response outputs default to zero so err/rdata only show with ack.
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
      case (state_r)
        IDLE: begin
          if (req_i) begin
            we_r    <= we_i;
            addr_r  <= addr_i;
            wdata_r <= wdata_i;
            cnt_r   <= WS_CNT;
          end
        end
        WAIT: begin
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        RESP: begin
          ack_r <= 1'b1;
          err_r <= ~in_range_s;
          if (in_range_s && !we_r) begin
            rdata_r <= mem_rdata_s;
          end
        end
        default: begin
          cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  assign ack_o   = ack_r;
  assign err_o   = err_r;
  assign rdata_o = rdata_r;
  assign busy_o  = (state_r != IDLE);

endmodule

// File: tb/tb_sys_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_sys_bus_responder
// Three responder instances share one clock and reset:
//   unit 0 : defaults (WAIT_STATES=1, BASE_ADDR=0, DEPTH=128)
//   unit 1 : WAIT_STATES=0
//   unit 2 : BASE_ADDR=0x40, DEPTH=16, WAIT_STATES=1
// Single transfers come from a vector table; back-to-back and reset-abort
// sequences are written out by hand.
// -----------------------------------------------------------------------------
module tb_sys_bus_responder;

  logic            CLK;
  logic            RST;
  logic [2:0]      req;
  logic [2:0]      we;
  logic [2:0][7:0] addr;
  logic [2:0][7:0] wdata;
  logic [2:0]      ack;
  logic [2:0]      err;
  logic [2:0][7:0] rdata;
  logic [2:0]      busy;

  int tests;
  int fails;

  typedef struct {
    int         unit;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       scr;    // change addr/wdata right after acceptance
    logic       err;
    logic [7:0] rdata;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  sys_bus_responder #(.WAIT_STATES(1)) u0 (
    .CLK(CLK), .RST(RST), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .ack_o(ack[0]), .err_o(err[0]), .rdata_o(rdata[0]),
    .busy_o(busy[0])
  );

  sys_bus_responder #(.WAIT_STATES(0)) u1 (
    .CLK(CLK), .RST(RST), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .ack_o(ack[1]), .err_o(err[1]), .rdata_o(rdata[1]),
    .busy_o(busy[1])
  );

  sys_bus_responder #(.BASE_ADDR(8'h40), .DEPTH(16), .WAIT_STATES(1)) u2 (
    .CLK(CLK), .RST(RST), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]),
    .wdata_i(wdata[2]), .ack_o(ack[2]), .err_o(err[2]), .rdata_o(rdata[2]),
    .busy_o(busy[2])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int ws_of(input int u);
    if (u == 1) return 0;
    else return 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete transfer on unit v.unit, with latency and response checks.
  task automatic xfer(input vec_t v);
    int   u;
    int   lat;
    logic quiet;
    u = v.unit;
    @(negedge CLK);
    req[u]   = 1'b1;
    we[u]    = v.we;
    addr[u]  = v.addr;
    wdata[u] = v.wdata;
    @(posedge CLK); #1;
    check("accept_busy", {31'd0, busy[u]}, 32'd1);
    check("accept_no_ack", {31'd0, ack[u]}, 32'd0);
    if (v.scr) begin
      addr[u]  = v.addr ^ 8'h01;
      wdata[u] = v.wdata ^ 8'hFF;
    end
    lat   = 0;
    quiet = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge CLK); #1;
      if (ack[u]) begin
        lat = n;
        break;
      end
      if (err[u] !== 1'b0 || rdata[u] !== 8'h00) quiet = 1'b0;
    end
    check("ack_latency", lat, ws_of(u) + 1);
    check("quiet_before_ack", {31'd0, quiet}, 32'd1);
    check("err", {31'd0, err[u]}, {31'd0, v.err});
    check("rdata", {24'd0, rdata[u]}, {24'd0, v.rdata});
    req[u] = 1'b0;
    @(posedge CLK); #1;
    check("ack_one_cycle", {30'd0, ack[u], busy[u]}, 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    req   = 3'b000;
    we    = 3'b000;
    addr  = '0;
    wdata = '0;
    RST   = 1'b1;

    //        unit we    addr   wdata  scr   err   rdata
    vecs[0]  = '{0, 1'b1, 8'h05, 8'hA5, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{0, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'hA5};
    vecs[2]  = '{0, 1'b1, 8'h07, 8'hC3, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{0, 1'b1, 8'h06, 8'h5A, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{0, 1'b0, 8'h06, 8'h00, 1'b0, 1'b0, 8'h5A};
    vecs[5]  = '{0, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0, 8'hC3};
    vecs[6]  = '{0, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[7]  = '{0, 1'b1, 8'hFF, 8'h12, 1'b0, 1'b1, 8'h00};
    vecs[8]  = '{1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h11};
    vecs[9]  = '{1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h22};
    vecs[10] = '{2, 1'b1, 8'h40, 8'h77, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{2, 1'b1, 8'h4F, 8'h88, 1'b0, 1'b0, 8'h00};
    vecs[12] = '{2, 1'b1, 8'h3F, 8'h11, 1'b0, 1'b1, 8'h00};
    vecs[13] = '{2, 1'b1, 8'h50, 8'h22, 1'b0, 1'b1, 8'h00};
    vecs[14] = '{2, 1'b0, 8'h4F, 8'h00, 1'b1, 1'b0, 8'h88};
    vecs[15] = '{2, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h77};
    vecs[16] = '{2, 1'b0, 8'h3F, 8'h00, 1'b0, 1'b1, 8'h00};

    // Reset state.
    #12;
    for (int u = 0; u < 3; u++) begin
      check("reset_state", {21'd0, ack[u], err[u], busy[u], rdata[u]}, 32'd0);
    end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Back-to-back writes with req held high on the zero-wait unit.
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h00; wdata[1] = 8'h11;
    @(posedge CLK); #1;
    check("b2b_accept0", {31'd0, ack[1]}, 32'd0);
    @(posedge CLK); #1;
    check("b2b_ack0", {30'd0, ack[1], err[1]}, 32'd2);
    addr[1] = 8'h01; wdata[1] = 8'h22;
    @(posedge CLK); #1;
    check("b2b_accept1", {30'd0, ack[1], busy[1]}, 32'd1);
    @(posedge CLK); #1;
    check("b2b_ack1", {30'd0, ack[1], err[1]}, 32'd2);
    req[1] = 1'b0;
    @(posedge CLK); #1;
    check("b2b_done", {30'd0, ack[1], busy[1]}, 32'd0);

    // Table-driven single transfers.
    for (int i = 0; i < NV; i++) begin
      xfer(vecs[i]);
    end

    // Reset during WAIT of a write 0x07=0x3C aborts it.
    @(negedge CLK);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h07; wdata[0] = 8'h3C;
    @(posedge CLK); #1;
    check("abort_in_wait", {31'd0, busy[0]}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("abort_async_busy", {30'd0, busy[0], ack[0]}, 32'd0);
    req[0] = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 3; n++) begin
        @(posedge CLK); #1;
        if (ack[0] !== 1'b0) seen = 1'b1;
      end
      check("abort_no_ack", {31'd0, seen}, 32'd0);
    end
    @(negedge CLK);
    RST = 1'b0;
    xfer('{0, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0, 8'hC3});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sys_bus_responder.md
SYS_BUS_RESPONDER -- requirements
Module: sys_bus_responder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width (matches CPU REG_SIZE).
REQ-002 The block SHALL have parameter ADDR_W, default 8, bus address width.
REQ-003 The block SHALL have parameter DEPTH, default 128, number of storage words.
REQ-004 The block SHALL have parameter BASE_ADDR, default 0, first address decoded by this responder.
REQ-005 The block SHALL have parameter WAIT_STATES, default 1 (range 0..15), extra cycles inserted before ack.
REQ-006 CLK  input  1  single clock; all logic SHALL be rising-edge.
REQ-007 RST  input  1  asynchronous, active-high reset.
REQ-008 req_i  input  1  initiator request; held high until ack_o is seen.
REQ-009 we_i  input  1  1 = write, 0 = read; valid while req_i high.
REQ-010 addr_i  input  ADDR_W  request address; valid while req_i high.
REQ-011 wdata_i  input  DATA_W  write data; valid while req_i high and we_i high.
REQ-012 ack_o  output  1  one-cycle completion pulse.
REQ-013 err_o  output  1  error flag; valid only with ack_o.
REQ-014 rdata_o  output  DATA_W  read data; valid only with ack_o.
REQ-015 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-017 In IDLE with req_i=1, the block SHALL latch we_i, addr_i and wdata_i, load wait counter with WAIT_STATES, and go to WAIT, or straight to RESP if WAIT_STATES=0.
REQ-018 In WAIT, the counter SHALL decrement each cycle; the transition to RESP SHALL occur on the cycle the counter reaches 1 -> 0.
REQ-019 ack_o SHALL be high for exactly one cycle, the RESP cycle, which SHALL occur WAIT_STATES+1 cycles after the accepting edge; then the FSM SHALL return to IDLE.
REQ-020 Inputs SHALL be ignored outside IDLE; changes to addr_i/we_i/wdata_i after acceptance SHALL have no effect.
REQ-021 req_i still high in the IDLE cycle after RESP SHALL be accepted as a new request (back-to-back throughput: one transfer per WAIT_STATES+2 cycles).
REQ-022 An address is in range iff BASE_ADDR <= addr < BASE_ADDR+DEPTH, using unsigned ADDR_W+1-bit arithmetic (no wrap-around).
REQ-023 In-range write: storage[addr-BASE_ADDR] SHALL be updated on the RESP edge; err_o=0 and rdata_o=0.
REQ-024 In-range read: rdata_o SHALL equal storage contents at RESP, including a write completed in the immediately preceding transfer; err_o=0.
REQ-025 Out-of-range access: the block SHALL respond with ack_o=1, err_o=1 and rdata_o=0, and SHALL NOT modify storage.
REQ-026 err_o and rdata_o SHALL be 0 in every cycle where ack_o=0.

Reset
REQ-027 RST=1 SHALL force state IDLE, counter 0, and ack_o, err_o, rdata_o and busy_o to 0 immediately, without waiting for a clock edge.
REQ-028 Reset during WAIT or RESP SHALL abort the transfer without a write or ack; the initiator SHALL re-issue it.
REQ-029 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-030 Package sys_bus_pkg SHALL hold the state enum (IDLE/WAIT/RESP) and the default width constants shared with the CPU bus side.
REQ-031 Storage SHALL be a sub-module sys_bus_mem_array, a synchronous single-port array of DEPTH x DATA_W with registered write and combinational read.
REQ-032 The FSM, counter, decode and response registers SHALL reside in sys_bus_responder.

Verification
REQ-033 WAIT_STATES=1: write addr 0x05 data 0xA5, then read 0x05 -> each ack_o exactly 2 cycles after accepting edge; read returns rdata_o=0xA5, err_o=0.
REQ-034 WAIT_STATES=0: back-to-back writes 0x00=0x11, 0x01=0x22 with req_i held high -> ack_o every 2nd cycle; readback gives 0x11 and 0x22.
REQ-035 BASE_ADDR=0x40, DEPTH=16: write to 0x3F and to 0x50 -> ack_o with err_o=1; storage is unchanged; read of 0x4F succeeds with err_o=0.
REQ-036 Request in flight: change addr_i/wdata_i during WAIT -> the originally latched address and data are used.
REQ-037 Assert RST in WAIT of a write 0x07=0x3C -> ack_o never pulses and busy_o drops asynchronously; a later read of 0x07 returns the prior value.
